// File: rtl/fb_port_arbiter.sv
// Two-requester arbiter in front of framebuffer port B: round-robin or fixed priority,
// with lock-based ownership for read-modify-write sequences and a saturating conflict counter.
module fb_port_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_0,
  input  logic [8:0]  addr_0,
  input  logic        wr_0,
  input  logic [15:0] wdata_0,
  input  logic        lock_0,
  output logic        gnt_0,
  output logic [15:0] rdata_0,
  output logic        rvalid_0,

  input  logic        req_1,
  input  logic [8:0]  addr_1,
  input  logic        wr_1,
  input  logic [15:0] wdata_1,
  input  logic        lock_1,
  output logic        gnt_1,
  output logic [15:0] rdata_1,
  output logic        rvalid_1,

  output logic [8:0]  buf_addr,
  output logic [15:0] buf_in,
  output logic        buf_enable,
  output logic        buf_write,
  input  logic [15:0] buf_out,

  output logic [15:0] conflicts
);

  typedef enum logic [1:0] {StFree, StOwn0, StOwn1} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;      // last winner: 0 = requester 0, 1 = requester 1
  logic [1:0]  rd_pend_q, rd_pend_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic [15:0] conflicts_q, conflicts_d;

  logic own0, own1;
  logic arb_g0, arb_g1;

  // Ownership only holds while the owner keeps lock asserted; the dropping cycle arbitrates freely.
  always_comb begin
    own0 = 1'b0;
    own1 = 1'b0;
    unique case (state_q)
      StOwn0:  own0 = lock_0;
      StOwn1:  own1 = lock_1;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFree;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!own0 && !own1) begin
      state_d = StFree;
      if (gnt_0 && lock_0) begin
        state_d = StOwn0;
      end else if (gnt_1 && lock_1) begin
        state_d = StOwn1;
      end
    end
    last_d = last_q;
    if (gnt_0) begin
      last_d = 1'b0;
    end else if (gnt_1) begin
      last_d = 1'b1;
    end
  end

  // Output logic: grant decision
  always_comb begin
    arb_g0 = 1'b0;
    arb_g1 = 1'b0;
    if (own0) begin
      arb_g0 = req_0;
    end else if (own1) begin
      arb_g1 = req_1;
    end else if (req_0 && req_1) begin
      if ((FIXED_PRIO != 0) || last_q) begin
        arb_g0 = 1'b1;
      end else begin
        arb_g1 = 1'b1;
      end
    end else begin
      arb_g0 = req_0;
      arb_g1 = req_1;
    end
    // No grants while reset is held, so nothing reaches the buffer.
    gnt_0 = arb_g0 & rst_n;
    gnt_1 = arb_g1 & rst_n;
  end

  // Framebuffer port B mux
  always_comb begin
    buf_addr   = '0;
    buf_in     = '0;
    buf_write  = 1'b0;
    buf_enable = gnt_0 | gnt_1;
    if (gnt_0) begin
      buf_addr  = addr_0;
      buf_in    = wdata_0;
      buf_write = wr_0;
    end else if (gnt_1) begin
      buf_addr  = addr_1;
      buf_in    = wdata_1;
      buf_write = wr_1;
    end
  end

  // Read return path: buffer data arrives one cycle after the granted read.
  always_comb begin
    rd_pend_d = {gnt_1 & ~wr_1, gnt_0 & ~wr_0};
    rdata0_d  = rd_pend_q[0] ? buf_out : rdata0_q;
    rdata1_d  = rd_pend_q[1] ? buf_out : rdata1_q;
    conflicts_d = conflicts_q;
    if (req_0 && req_1 && (conflicts_q != 16'hFFFF)) begin
      conflicts_d = conflicts_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q   <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      conflicts_q <= '0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign rvalid_0  = rd_pend_q[0];
  assign rvalid_1  = rd_pend_q[1];
  assign rdata_0   = rdata0_d;
  assign rdata_1   = rdata1_d;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: grant table, read scoreboard, lock/RMW/reset/saturation.
module tb_fb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_0, wr_0, lock_0, gnt_0, rvalid_0;
  logic        req_1, wr_1, lock_1, gnt_1, rvalid_1;
  logic [8:0]  addr_0, addr_1, buf_addr;
  logic [15:0] wdata_0, wdata_1, rdata_0, rdata_1;
  logic [15:0] buf_in, buf_out, conflicts;
  logic        buf_enable, buf_write;

  fb_port_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .addr_0(addr_0), .wr_0(wr_0), .wdata_0(wdata_0), .lock_0(lock_0),
    .gnt_0(gnt_0), .rdata_0(rdata_0), .rvalid_0(rvalid_0),
    .req_1(req_1), .addr_1(addr_1), .wr_1(wr_1), .wdata_1(wdata_1), .lock_1(lock_1),
    .gnt_1(gnt_1), .rdata_1(rdata_1), .rvalid_1(rvalid_1),
    .buf_addr(buf_addr), .buf_in(buf_in), .buf_enable(buf_enable), .buf_write(buf_write),
    .buf_out(buf_out), .conflicts(conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer port B model: synchronous read, one cycle latency.
  logic [15:0] fb_mem [512];
  logic [15:0] exp_mem [512];
  always @(posedge clk) begin
    if (buf_enable) begin
      if (buf_write) fb_mem[buf_addr] <= buf_in;
      else           buf_out <= fb_mem[buf_addr];
    end
  end

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 257) ^ 16'h3C00;
  endfunction

  typedef struct packed {
    bit r0, r1, l0, l1, w0, w1, g0, g1;
  } row_t;
  typedef struct {
    bit          who;
    logic [15:0] data;
  } rd_t;

  row_t        rows [17];
  rd_t         sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_conf;
  logic [15:0] last_rd0, last_rd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // One cycle: drive (just after posedge), check at negedge, update model, advance.
  task automatic step(input bit r0, input bit r1, input bit l0, input bit l1,
                      input bit w0, input bit w1, input logic [8:0] a0, input logic [8:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input bit eg0, input bit eg1, input string nm);
    rd_t e;
    bit  ev0, ev1;
    req_0 = r0; req_1 = r1; lock_0 = l0; lock_1 = l1;
    wr_0 = w0; wr_1 = w1; addr_0 = a0; addr_1 = a1; wdata_0 = d0; wdata_1 = d1;
    @(negedge clk);
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (e.who) begin ev1 = 1'b1; last_rd1 = e.data; end
      else       begin ev0 = 1'b1; last_rd0 = e.data; end
    end
    chk({nm, " rvalid_0"}, 32'(rvalid_0), 32'(ev0));
    chk({nm, " rvalid_1"}, 32'(rvalid_1), 32'(ev1));
    chk({nm, " rdata_0"}, 32'(rdata_0), 32'(last_rd0));
    chk({nm, " rdata_1"}, 32'(rdata_1), 32'(last_rd1));
    chk({nm, " gnt_0"}, 32'(gnt_0), 32'(eg0));
    chk({nm, " gnt_1"}, 32'(gnt_1), 32'(eg1));
    chk({nm, " buf_enable"}, 32'(buf_enable), 32'(eg0 | eg1));
    chk({nm, " conflicts"}, 32'(conflicts), 32'(exp_conf));
    if (eg0 || eg1) begin
      chk({nm, " buf_addr"}, 32'(buf_addr), eg0 ? 32'(a0) : 32'(a1));
      chk({nm, " buf_write"}, 32'(buf_write), eg0 ? 32'(w0) : 32'(w1));
      if (eg0 ? w0 : w1) begin
        chk({nm, " buf_in"}, 32'(buf_in), eg0 ? 32'(d0) : 32'(d1));
        if (eg0) exp_mem[a0] = d0;
        else     exp_mem[a1] = d1;
      end else begin
        e.who  = eg1;
        e.data = eg0 ? exp_mem[a0] : exp_mem[a1];
        sb_q.push_back(e);
      end
    end else begin
      chk({nm, " buf_write"}, 32'(buf_write), 32'd0);
    end
    if (r0 && r1 && exp_conf != 16'hFFFF) exp_conf = exp_conf + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    step(0, 0, 0, 0, 0, 0, 9'h0, 9'h0, 16'h0, 16'h0, 0, 0, nm);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_0 = 1'b1; req_1 = 1'b1; wr_0 = 1'b1; wr_1 = 1'b1; lock_0 = 1'b0; lock_1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst gnt_0", 32'(gnt_0), 32'd0);
    chk("rst gnt_1", 32'(gnt_1), 32'd0);
    chk("rst buf_enable", 32'(buf_enable), 32'd0);
    chk("rst buf_write", 32'(buf_write), 32'd0);
    chk("rst rvalid", 32'({rvalid_1, rvalid_0}), 32'd0);
    chk("rst rdata_0", 32'(rdata_0), 32'd0);
    chk("rst rdata_1", 32'(rdata_1), 32'd0);
    chk("rst conflicts", 32'(conflicts), 32'd0);
    req_0 = 1'b0; req_1 = 1'b0; wr_0 = 1'b0; wr_1 = 1'b0;
    rst_n = 1'b1;
    sb_q.delete();
    exp_conf = '0;
    last_rd0 = '0;
    last_rd1 = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      fb_mem[i]  = pat(i);
      exp_mem[i] = pat(i);
    end
    fb_mem[5]  = 16'hA5A5;
    exp_mem[5] = 16'hA5A5;
    buf_out = '0;
    rst_n = 1'b0;
    req_0 = 0; req_1 = 0; wr_0 = 0; wr_1 = 0; lock_0 = 0; lock_1 = 0;
    addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;

    // bits: r0 r1 l0 l1 w0 w1 g0 g1
    rows[0]  = 8'b1100_0010; rows[1]  = 8'b1100_0001; rows[2]  = 8'b1100_0110;
    rows[3]  = 8'b1100_0001; rows[4]  = 8'b0100_0101; rows[5]  = 8'b1000_1010;
    rows[6]  = 8'b0010_0000; rows[7]  = 8'b0110_0001; rows[8]  = 8'b1010_0010;
    rows[9]  = 8'b0110_0000; rows[10] = 8'b1110_1010; rows[11] = 8'b0100_0001;
    rows[12] = 8'b1101_0010; rows[13] = 8'b1101_0001; rows[14] = 8'b1001_0000;
    rows[15] = 8'b1101_0101; rows[16] = 8'b1000_0010;

    apply_reset();
    for (int i = 0; i < 17; i++) begin
      step(rows[i].r0, rows[i].r1, rows[i].l0, rows[i].l1, rows[i].w0, rows[i].w1,
           9'(32'h20 + i), 9'(32'h40 + i), 16'(32'h1000 + i), 16'(32'h2000 + i),
           rows[i].g0, rows[i].g1, $sformatf("row%0d", i));
    end
    idle("table drain");
    idle("table drain2");

    // Single read
    apply_reset();
    step(1, 0, 0, 0, 0, 0, 9'h005, 9'h0, 16'h0, 16'h0, 1, 0, "single rd");
    idle("single rvalid");
    idle("single after");

    // Lock held against requester 1, released with requester 0 idle
    apply_reset();
    step(1, 0, 1, 0, 0, 0, 9'h007, 9'h0, 16'h0, 16'h0, 1, 0, "lock take");
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0, 0, 0, 9'h007, 9'h008, 16'h0, 16'h0, 0, 0, $sformatf("lock hold%0d", i));
    end
    step(0, 1, 0, 0, 0, 0, 9'h007, 9'h008, 16'h0, 16'h0, 0, 1, "lock drop");
    idle("lock drain");

    // Lock released with both requesting: round-robin picks requester 1
    apply_reset();
    step(1, 0, 1, 0, 0, 0, 9'h009, 9'h0, 16'h0, 16'h0, 1, 0, "lock2 take");
    step(0, 1, 1, 0, 0, 0, 9'h009, 9'h00A, 16'h0, 16'h0, 0, 0, "lock2 hold");
    step(1, 1, 0, 0, 0, 0, 9'h009, 9'h00A, 16'h0, 16'h0, 0, 1, "lock2 drop rr");
    idle("lock2 drain");

    // Read-modify-write under lock, then requester 1 reads back
    apply_reset();
    step(1, 1, 1, 0, 0, 0, 9'h010, 9'h010, 16'h0, 16'h0, 1, 0, "rmw rd");
    step(1, 1, 1, 0, 1, 0, 9'h010, 9'h010, 16'h0F0F, 16'h0, 1, 0, "rmw wr");
    step(0, 1, 0, 0, 0, 0, 9'h010, 9'h010, 16'h0, 16'h0, 0, 1, "rmw rd1");
    idle("rmw readback");

    // Reset asserted in the grant cycle of a read
    apply_reset();
    req_0 = 1; req_1 = 1; addr_0 = 9'h005; wr_0 = 0; lock_0 = 0; lock_1 = 0; wr_1 = 1;
    @(negedge clk);
    chk("midrst gnt_0", 32'(gnt_0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst gnt_0 low", 32'(gnt_0), 32'd0);
    chk("midrst buf_enable", 32'(buf_enable), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst rvalid_0", 32'(rvalid_0), 32'd0);
    chk("midrst conflicts", 32'(conflicts), 32'd0);
    chk("midrst rdata_0", 32'(rdata_0), 32'd0);
    req_0 = 0; req_1 = 0; wr_1 = 0;
    rst_n = 1'b1;
    sb_q.delete();
    exp_conf = '0;
    last_rd0 = '0;
    last_rd1 = '0;
    @(posedge clk);
    #1;
    idle("midrst post1");
    idle("midrst post2");

    // Conflict counter saturation
    apply_reset();
    req_0 = 1; req_1 = 1; wr_0 = 1; wr_1 = 1; addr_0 = 9'h1F0; addr_1 = 9'h1F1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat 65534", 32'(conflicts), 32'hFFFE);
    @(posedge clk);
    #1;
    chk("sat 65535", 32'(conflicts), 32'hFFFF);
    repeat (4465) @(posedge clk);
    #1;
    chk("sat 70000", 32'(conflicts), 32'hFFFF);
    req_0 = 0; req_1 = 0; wr_0 = 0; wr_1 = 0;
    apply_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
